// File: rtl/seg_pkg.sv
// Shared constants, 7-segment decode and FSM state type for the BCD display path.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_DIGITS = 10;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 32-bit binary to 10-digit BCD converter (shift-add-3, one bit per clock).
// done is high for exactly the one cycle spent in COMMIT, while bcd holds the final result.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic [39:0] bcd
);

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_bin;
  logic [39:0] r_bcd;
  logic [39:0] w_bcd_adj;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5)
        w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_bin   <= bin;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          {r_bcd, r_bin} <= {w_bcd_adj[38:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_done  <= 1'b1;
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: rtl/seg_display_bcd.sv
// Decimal readout of a 32-bit sum on eight multiplexed active-low 7-segment digits.
// Define SEG_LEADING_ZERO_BLANK_EN to blank digits above the most significant non-zero one.
module seg_display_bcd
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [7:0]  AN,
  output logic [7:0]  SEG
);

  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic        w_conv_busy;
  logic        w_conv_done;
  logic [39:0] w_bcd;

  logic [31:0]       r_buf;
  logic              r_ovf;
  logic              r_done;
  logic [TICK_W-1:0] r_tick;
  logic [2:0]        r_idx;
  logic [7:0]        r_an;
  logic [7:0]        r_seg;
  logic [3:0]        w_digit;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (load),
    .bin   (value),
    .busy  (w_conv_busy),
    .done  (w_conv_done),
    .bcd   (w_bcd)
  );

  // Second buffer: the screen keeps the last result until the converter commits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_buf  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_conv_done;
      if (w_conv_done) begin
        r_buf <= w_bcd[31:0];
        r_ovf <= |w_bcd[39:32];
      end
    end
  end

  assign w_digit = r_buf[{r_idx, 2'b00} +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [2:0] w_msd;

  always_comb begin
    w_msd = 3'd0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (r_buf[i*4 +: 4] != 4'd0)
        w_msd = 3'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tick <= '0;
      r_idx  <= '0;
      r_an   <= 8'hFF;
      r_seg  <= SEG_BLANK;
    end else begin
      if (r_tick == TICK_W'(SCAN_DIV - 1)) begin
        r_tick <= '0;
        r_idx  <= r_idx + 3'd1;
      end else begin
        r_tick <= r_tick + TICK_W'(1);
      end
      r_an  <= ~(8'b1 << r_idx);
      r_seg <= r_ovf ? SEG_DASH : seg_decode(w_digit);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (!r_ovf && (r_idx > w_msd)) begin
        r_an  <= 8'hFF;
        r_seg <= SEG_BLANK;
      end
`endif
    end
  end

  assign busy = w_conv_busy;
  assign done = r_done;
  assign ovf  = r_ovf;
  assign AN   = r_an;
  assign SEG  = r_seg;

endmodule

// File: tb/tb_seg_display_bcd.sv
// Self-checking bench for seg_display_bcd: directed and random loads against a decimal display model.
module tb_seg_display_bcd;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [7:0]  AN;
  logic [7:0]  SEG;

  int checks = 0;
  int errors = 0;
  longint ecount = 0;
  longint unsigned model_v = 0;

  seg_display_bcd #(.SCAN_DIV(SD)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .value (value),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .AN    (AN),
    .SEG   (SEG)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the scanned digit follows from this alone.
  always @(posedge clk) begin
    if (!rst) ecount <= 0;
    else      ecount <= ecount + 1;
  end

  initial begin
    #500us;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] dec(input int d);
    logic [7:0] t [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return t[d];
  endfunction

  function automatic void expect_digit(input int i, output logic [7:0] an,
                                       output logic [7:0] sg);
    longint unsigned p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    an = ~(8'(1) << i);
    if (model_v > 64'd99999999) begin
      sg = 8'hBF;
      return;
    end
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (i > 0 && model_v < p) begin
      an = 8'hFF;
      sg = 8'hFF;
      return;
    end
`endif
    sg = dec(int'((model_v / p) % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scan_check(input string tag);
    logic [7:0] ean, esg;
    int idx;
    for (int c = 0; c < 8 * SD; c++) begin
      @(posedge clk); #1;
      idx = int'(((ecount - 1) / SD) % 8);
      expect_digit(idx, ean, esg);
      chk({tag, "_an"}, {24'd0, AN}, {24'd0, ean});
      chk({tag, "_seg"}, {24'd0, SEG}, {24'd0, esg});
    end
  endtask

  task automatic wait_done(input int start_cnt, input string tag);
    int cnt = start_cnt;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!done && cnt < 45);
    chk({tag, "_latency"}, cnt, 33);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic do_load(input logic [31:0] v, input string tag);
    @(negedge clk);
    load = 1'b1;
    value = v;
    @(posedge clk); #1;
    load = 1'b0;
    chk({tag, "_busy_hi"}, {31'd0, busy}, 32'd1);
    wait_done(0, tag);
    model_v = v;
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, (v > 32'd99999999)});
    @(posedge clk); #1;
    chk({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_lo"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int seen;
    logic [31:0] rv;
    rst = 1'b0;
    load = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {24'd0, AN}, 32'h0000_00FF);
    chk("rst_seg", {24'd0, SEG}, 32'h0000_00FF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_v = 0;
    scan_check("post_rst");

    do_load(32'd12345678, "l12345678");
    scan_check("s12345678");
    do_load(32'd0, "l0");
    scan_check("s0");
    do_load(32'd100, "l100");
    scan_check("s100");
    do_load(32'd100000000, "l1e8");
    scan_check("s1e8");
    do_load(32'd99999999, "l99999999");
    scan_check("s99999999");

    // Load 5, then a second load of 77 while busy must be dropped.
    @(negedge clk);
    load = 1'b1;
    value = 32'd5;
    @(posedge clk); #1;
    load = 1'b0;
    value = 32'd0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    load = 1'b1;
    value = 32'd77;
    @(posedge clk); #1;
    load = 1'b0;
    chk("ign_busy", {31'd0, busy}, 32'd1);
    wait_done(10, "ign");
    model_v = 5;
    @(posedge clk); #1;
    chk("ign_busy_lo", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_no_requeue", {31'd0, busy}, 32'd0);
    scan_check("s5");

    // Reset in the middle of a conversion.
    @(negedge clk);
    load = 1'b1;
    value = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    chk("mid_an", {24'd0, AN}, 32'h0000_00FF);
    chk("mid_seg", {24'd0, SEG}, 32'h0000_00FF);
    chk("mid_ovf", {31'd0, ovf}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_v = 0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("mid_no_done", seen, 0);
    scan_check("s_after_abort");
    do_load(32'd42, "l42");
    scan_check("s42");

    for (int i = 0; i < 6; i++) begin
      rv = (i % 2 == 1) ? $urandom : $urandom_range(99999999, 0);
      do_load(rv, "lrand");
      scan_check("srand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
